// File: rtl/md_unit_if.sv
// md_unit_if: groups the execute-stage HI/LO operation signals of md_unit.
//   md_valid  E-stage holds a valid HI/LO-class op this cycle
//   md_op     0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   rs_val    forwarded GPR[rs] (dividend / multiplicand / MT data)
//   rt_val    forwarded GPR[rt] (divisor / multiplier)
//   mf_sel    0 selects HI, 1 selects LO on md_rdata
//   busy      operation in progress
//   md_stall  busy | start request, to the hazard/stall unit
//   hi, lo    architectural HI/LO registers
//   md_rdata  MFHI/MFLO read data
interface md_unit_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_sel;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output md_valid, md_op, rs_val, rt_val, mf_sel,
        input  busy, md_stall, hi, lo, md_rdata
    );

    modport slave (
        input  md_valid, md_op, rs_val, rt_val, mf_sel,
        output busy, md_stall, hi, lo, md_rdata
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit with architectural HI/LO.
// The result of MULT/MULTU/DIV/DIVU is computed and held in pending
// registers on the start edge, then committed to HI/LO after a fixed
// busy period. MTHI/MTLO write when idle; md_rdata serves MFHI/MFLO.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    md_unit_if slave modport (operation inputs, status, HI/LO)
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    md_op_e          op;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;
    logic            busy, is_md, start;

    logic [31:0]     rs, rt;
    logic [63:0]     prod_s, prod_u;
    logic            div_zero;
    logic [31:0]     abs_a, abs_b, uq, ur, sq, sr;
    logic [31:0]     divu_b, divu_q, divu_r;

    assign op    = md_op_e'(bus.md_op);
    assign rs    = bus.rs_val;
    assign rt    = bus.rt_val;
    assign busy  = (cnt_q != '0);
    assign is_md = bus.md_valid &&
                   (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
    assign start = is_md && !busy;

    // Lower 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes: avoids host-level INT_MIN/-1 overflow and
    // naturally yields 0x80000000 / -1 = 0x80000000 rem 0. Divisor forced to 1
    // on divide-by-zero; the result is discarded in that case anyway.
    always_comb begin
        div_zero = (rt == '0);
        abs_a    = rs[31] ? (~rs + 32'd1) : rs;
        abs_b    = div_zero ? 32'd1 : (rt[31] ? (~rt + 32'd1) : rt);
        uq       = abs_a / abs_b;
        ur       = abs_a % abs_b;
        sq       = (rs[31] ^ rt[31]) ? (~uq + 32'd1) : uq;
        sr       = rs[31] ? (~ur + 32'd1) : ur;
        divu_b   = div_zero ? 32'd1 : rt;
        divu_q   = rs / divu_b;
        divu_r   = rs % divu_b;
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (start) begin
            unique case (op)
                OP_MULT: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CW'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CW'(MULT_CYCLES);
                end
                OP_DIV: begin
                    pend_hi_d = sr;
                    pend_lo_d = sq;
                    pend_wr_d = !div_zero;
                    cnt_d     = CW'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pend_hi_d = divu_r;
                    pend_lo_d = divu_q;
                    pend_wr_d = !div_zero;
                    cnt_d     = CW'(DIV_CYCLES);
                end
                default: ;
            endcase
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (bus.md_valid) begin
            if (op == OP_MTHI) hi_d = rs;
            if (op == OP_MTLO) lo_d = rs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.md_stall = busy | is_md;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_rdata = bus.mf_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit. Stimulus pushes the expected
// HI/LO and busy length of each operation into a scoreboard queue; a
// monitor pops and checks on every commit (busy falling).
module tb_md_unit;

    logic clk;
    logic reset;
    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned n;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: counts busy and stall cycles, checks each commit.
    bit          prev_busy = 1'b0;
    int unsigned bcnt = 0;
    int unsigned scnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_busy = 1'b0;
            bcnt = 0;
            scnt = 0;
        end else begin
            if (bus.md_stall) scnt++;
            if (bus.busy) bcnt++;
            if (prev_busy && !bus.busy) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", bus.hi, bus.lo);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_hi"}, bus.hi, e.hi);
                    chk({e.nm, "_lo"}, bus.lo, e.lo);
                    chk({e.nm, "_busy_cycles"}, 32'(bcnt), 32'(e.n));
                    chk({e.nm, "_stall_cycles"}, 32'(scnt), 32'(e.n + 1));
                end
                bcnt = 0;
                scnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l, input int unsigned n);
        exp_t e;
        e.nm = nm; e.hi = h; e.lo = l; e.n = n;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit is_md);
        @(posedge clk); #1;
        bus.md_valid = 1'b1;
        bus.md_op    = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        #1;
        if (is_md) begin
            chk("stall_on_start", 32'(bus.md_stall), 32'd1);
            chk("busy_on_start", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        bus.md_op    = 3'd0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input int unsigned n);
        push(nm, h, l, n);
        issue(op, a, b, 1'b1);
        repeat (n + 2) @(posedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] h, input logic [31:0] l);
        #1 bus.mf_sel = 1'b0;
        #1 chk({nm, "_mfhi"}, bus.md_rdata, h);
        bus.mf_sel = 1'b1;
        #1 chk({nm, "_mflo"}, bus.md_rdata, l);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        bus.md_valid = 1'b0;
        bus.md_op    = 3'd0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.mf_sel   = 1'b0;
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall", 32'(bus.md_stall), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        run_op("mult_m3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        rd_chk("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_ffx2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        run_op("mult_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op("div_m7d2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divu_7d2", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

        issue(3'd5, 32'h11, 32'd0, 1'b0);
        issue(3'd6, 32'h22, 32'd0, 1'b0);
        rd_chk("mt_preload", 32'h11, 32'h22);
        run_op("divu_by0", 3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10);

        // Collision: DIV and MTHI presented during busy cycles 2 and 3.
        push("mult_collide", 32'd0, 32'd42, 5);
        issue(3'd1, 32'd6, 32'd7, 1'b1);
        @(posedge clk); #1;
        bus.md_valid = 1'b1; bus.md_op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
        @(posedge clk); #1;
        bus.md_op = 3'd5; bus.rs_val = 32'h0000_ABCD;
        @(posedge clk); #1;
        bus.md_valid = 1'b0; bus.md_op = 3'd0;
        chk("collide_mthi_ignored", bus.hi, 32'h11);
        repeat (5) @(posedge clk);

        // Reset during busy cycle 3 aborts the op.
        issue(3'd5, 32'h55, 32'd0, 1'b0);
        issue(3'd2, 32'd3, 32'd4, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_stall", 32'(bus.md_stall), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_abort_busy", 32'(bus.busy), 32'd0);
        chk("post_abort_hi", bus.hi, 32'd0);
        chk("post_abort_lo", bus.lo, 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency.
- Drives md_stall to the hazard/stall unit, which freezes D on any HI/LO-touching instruction while md_stall is high.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- md_valid  input  1  E-stage instruction is a valid HI/LO-class op this cycle.
- md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rs_val  input  32  forwarded GPR[rs] (dividend / multiplicand / MT data).
- rt_val  input  32  forwarded GPR[rt] (divisor / multiplier).
- mf_sel  input  1  0 selects HI, 1 selects LO on md_rdata.
- busy  output  1  operation in progress.
- md_stall  output  1  busy | start; feeds the stall unit.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_rdata  output  32  mf_sel ? lo : hi (combinational).

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, counter=0, busy=0, pending results=0. md_stall=0 unless start is asserted.
- Definition: start = md_valid & (md_op in 1..4) & !busy.
- md_stall = busy | (md_valid & md_op in 1..4), combinational. The start cycle itself stalls D, so a following MF/MT/MD in D waits.
- Start edge:
  - Compute the 64-bit product or quotient/remainder from rs_val/rt_val into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Behavioural * and / are allowed; result registered at start.
- Count: counter decrements once per edge while nonzero. busy = (counter != 0).
- Commit: on the edge where counter goes 1->0, hi<=pending_hi and lo<=pending_lo.
  - After a start at edge T, busy is high T+1..T+N and the new hi/lo are visible from edge T+N (N = cycle count).
  - busy falls in the same cycle the result appears.
- Arithmetic:
  - MULT: signed 32x32->64, HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32x32->64.
  - DIV: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (rt_val=0, DIV or DIVU): full DIV_CYCLES busy period; commit leaves hi/lo unchanged.
- MTHI/MTLO: when md_valid & !busy, hi or lo <= rs_val at the edge. When busy, the write is ignored; the stall unit guarantees this case does not occur.
- Start while busy is ignored: no reload, no operand capture.
- md_valid=0 means no state change except the counter decrement.
- Reset mid-operation aborts the op: busy=0 immediately, hi/lo=0, pending discarded.
- No flush input: a started op always commits.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; md_stall high on the start cycle plus 5 more.
- MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE. Signed MULT of the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Collision and reset:
  - MULT started, then at busy cycle 2 present DIV and MTHI 0xABCD -> both ignored; MULT result commits at cycle 5.
  - Separate run: assert reset low at busy cycle 3 -> busy=0, hi=lo=0 immediately; no commit afterwards.
